mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Shares the CPU's single memory port between instruction fetch and the load/store unit in the multi-cycle core. It accepts the one-cycle fetch/memory start pulses from the stage sequencer and holds them until served. It runs one memory transaction at a time over a valid/ready handshake and returns read data with a done pulse. While any request is pending or in flight it drives `blocked` back to the stage sequencer to freeze stage advance.

## Interface
Parameters:
- `ADDR_WIDTH`, default 32: address width.
- `DATA_WIDTH`, default 32: data width; the write mask is `DATA_WIDTH/8` bits.
- `TIMEOUT`, default 255: maximum wait cycles for `mem_ready`; 0 disables the timeout.

Ports:
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `fetch_req`  in  1  one-cycle fetch request pulse.
- `fetch_addr`  in  ADDR_WIDTH  instruction address; sampled on the request cycle.
- `fetch_data`  out  DATA_WIDTH  last fetched instruction; held until the next fetch completes.
- `fetch_done`  out  1  one-cycle completion pulse.
- `data_req`  in  1  one-cycle load/store request pulse.
- `data_we`  in  1  1 = store, 0 = load; sampled with `data_req`.
- `data_addr`  in  ADDR_WIDTH  load/store address; sampled with `data_req`.
- `data_wdata`  in  DATA_WIDTH  store data; sampled with `data_req`.
- `data_wmask`  in  DATA_WIDTH/8  store byte enables; sampled with `data_req`.
- `data_rdata`  out  DATA_WIDTH  last load result; unchanged by stores.
- `data_done`  out  1  one-cycle completion pulse.
- `mem_valid`  out  1  transaction request to memory.
- `mem_addr`, `mem_we`, `mem_wdata`, `mem_wmask`  out  ADDR_WIDTH / 1 / DATA_WIDTH / DATA_WIDTH/8  transaction fields; stable while `mem_valid` is high.
- `mem_ready`  in  1  memory accepts and completes the transaction.
- `mem_rdata`  in  DATA_WIDTH  read data; valid when `mem_ready` is high.
- `blocked`  out  1  stall to the stage sequencer.
- `err`  out  1  sticky error flag (timeout or request overrun).

## Operation
- Each requester has a one-deep pending register holding its request flag and captured fields. A `*_req` pulse sets the pending register on the next edge.
- FSM states:
  - IDLE: if data is pending, go to DATA; else if fetch is pending, go to FETCH.
  - FETCH / DATA: `mem_valid`=1, with fields taken from that requester's pending register.
  - On an edge with `mem_valid && mem_ready`:
    - clear that pending register;
    - for FETCH, latch `mem_rdata` into `fetch_data`; for a DATA load, latch it into `data_rdata`;
    - pulse `fetch_done` / `data_done` for the following cycle;
    - go straight to the other requester's state if it is pending, else to IDLE.
- Priority: data over fetch. When both arrive in the same cycle, data is served first and fetch stays pending.
- `blocked` = `fetch_req | data_req | fetch_pending | data_pending`. It is combinational from the request inputs, so the sequencer freezes in the same cycle as the pulse.
- Overrun: a `*_req` while that requester is already pending or in flight is ignored and sets `err`.
- Timeout: a counter increments on each cycle with `mem_valid && !mem_ready` and clears on every handshake.
  - When it reaches `TIMEOUT` (nonzero), the transaction is aborted: `mem_valid` drops and the pending register clears.
  - The done pulse is still issued. A load returns 0. `err` is set.
- `err` clears only on reset.

## Timing
- Reset values, applied immediately on `rst` assertion, mid-transaction included:
  - FSM = IDLE; pending registers and timeout counter = 0;
  - `mem_valid`, `fetch_done`, `data_done`, `err` = 0;
  - `fetch_data`, `data_rdata`, `mem_addr`, `mem_wdata`, `mem_wmask`, `mem_we` = 0;
  - `blocked` = 0 (unless a request input is high).
- Minimum latency, with request at cycle N:
  - `mem_valid` high at N+1;
  - with `mem_ready` high at N+1, the done pulse and updated read data appear at N+2;
  - `blocked` low at N+2 if nothing else is pending.
- Back-to-back service: `mem_valid` stays high across the switch and the fields change on the handshake edge, with no idle cycle between transactions.
- `mem_*` fields never change while `mem_valid` is high without a handshake.

## Test plan
- Load: `data_req`, we=0, addr=0x100; `mem_ready` after 3 wait cycles with rdata=0xDEADBEEF -> `mem_valid` held for 4 cycles, `data_done` pulses once, `data_rdata`=0xDEADBEEF, `blocked` high from the request cycle through the handshake cycle.
- Simultaneous `fetch_req`(0x40) and `data_req` store(0x200, wdata 0x11223344, mask 0xF) -> store issued first, fetch at 0x40 issued on the next cycle with no gap, `data_rdata` unchanged, both done pulses one cycle apart.
- Fetch with `mem_ready` tied high -> `mem_valid` at N+1, `fetch_done` and `fetch_data` valid at N+2, `blocked` low at N+2.
- Second `fetch_req` while a fetch is in flight -> ignored, `err`=1 and remains 1 until `rst`; only one `fetch_done`.
- `TIMEOUT`=4, `mem_ready` held low -> abort after 4 wait cycles, `data_done` pulses, load `data_rdata`=0, `err`=1.
- `rst` asserted mid-wait -> `mem_valid`, `blocked`, and `err` go to 0 asynchronously; after release, no done pulse is issued for the aborted transaction.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares the single memory port between instruction fetch and the load/store unit.
// One transaction at a time; data has priority; each requester holds one pending request.
module mem_port_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    fetch_req,
  input  logic [ADDR_WIDTH-1:0]   fetch_addr,
  output logic [DATA_WIDTH-1:0]   fetch_data,
  output logic                    fetch_done,
  input  logic                    data_req,
  input  logic                    data_we,
  input  logic [ADDR_WIDTH-1:0]   data_addr,
  input  logic [DATA_WIDTH-1:0]   data_wdata,
  input  logic [DATA_WIDTH/8-1:0] data_wmask,
  output logic [DATA_WIDTH-1:0]   data_rdata,
  output logic                    data_done,
  output logic                    mem_valid,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic                    mem_we,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wmask,
  input  logic                    mem_ready,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    blocked,
  output logic                    err
);

  localparam int unsigned MASK_W = DATA_WIDTH / 8;
  localparam int unsigned CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_DATA} state_t;

  state_t state_q, state_d;

  logic                  fetch_pend;
  logic [ADDR_WIDTH-1:0] fetch_addr_q;
  logic                  data_pend;
  logic                  data_we_q;
  logic [ADDR_WIDTH-1:0] data_addr_q;
  logic [DATA_WIDTH-1:0] data_wdata_q;
  logic [MASK_W-1:0]     data_wmask_q;
  logic [CNT_W-1:0]      tcnt;

  logic fetch_acc_c, data_acc_c, fetch_eff_c, data_eff_c;
  logic wait_c, hs_c, abort_c, end_c, fetch_end_c, data_end_c, load_c;
  logic [ADDR_WIDTH-1:0] nxt_addr_c;
  logic                  nxt_we_c;
  logic [DATA_WIDTH-1:0] nxt_wdata_c;
  logic [MASK_W-1:0]     nxt_wmask_c;

  // A request is accepted only when its requester has nothing pending or in flight.
  assign fetch_acc_c = fetch_req & ~fetch_pend;
  assign data_acc_c  = data_req & ~data_pend;
  assign fetch_eff_c = fetch_pend | fetch_req;
  assign data_eff_c  = data_pend | data_req;

  assign mem_valid   = (state_q != ST_IDLE);
  assign wait_c      = mem_valid & ~mem_ready;
  assign hs_c        = mem_valid & mem_ready;
  assign abort_c     = (TIMEOUT != 0) && wait_c && (tcnt == CNT_LAST);
  assign end_c       = hs_c | abort_c;
  assign fetch_end_c = end_c && (state_q == ST_FETCH);
  assign data_end_c  = end_c && (state_q == ST_DATA);
  assign load_c      = (state_d != state_q) && (state_d != ST_IDLE);

  assign blocked = fetch_req | data_req | fetch_pend | data_pend;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state: data wins ties; handshake hands straight over to the other requester.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (data_eff_c)       state_d = ST_DATA;
        else if (fetch_eff_c) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (abort_c)   state_d = ST_IDLE;
        else if (hs_c) state_d = data_eff_c ? ST_DATA : ST_IDLE;
      end
      ST_DATA: begin
        if (abort_c)   state_d = ST_IDLE;
        else if (hs_c) state_d = fetch_eff_c ? ST_FETCH : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Fields for the transaction being launched, from the pending register or the live request.
  always_comb begin
    nxt_addr_c  = fetch_pend ? fetch_addr_q : fetch_addr;
    nxt_we_c    = 1'b0;
    nxt_wdata_c = '0;
    nxt_wmask_c = '0;
    if (state_d == ST_DATA) begin
      nxt_addr_c  = data_pend ? data_addr_q  : data_addr;
      nxt_we_c    = data_pend ? data_we_q    : data_we;
      nxt_wdata_c = data_pend ? data_wdata_q : data_wdata;
      nxt_wmask_c = data_pend ? data_wmask_q : data_wmask;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pend   <= 1'b0;
      fetch_addr_q <= '0;
      data_pend    <= 1'b0;
      data_we_q    <= 1'b0;
      data_addr_q  <= '0;
      data_wdata_q <= '0;
      data_wmask_q <= '0;
      tcnt         <= '0;
      fetch_data   <= '0;
      fetch_done   <= 1'b0;
      data_rdata   <= '0;
      data_done    <= 1'b0;
      mem_addr     <= '0;
      mem_we       <= 1'b0;
      mem_wdata    <= '0;
      mem_wmask    <= '0;
      err          <= 1'b0;
    end else begin
      if (fetch_acc_c) begin
        fetch_pend   <= 1'b1;
        fetch_addr_q <= fetch_addr;
      end else if (fetch_end_c) begin
        fetch_pend   <= 1'b0;
      end

      if (data_acc_c) begin
        data_pend    <= 1'b1;
        data_we_q    <= data_we;
        data_addr_q  <= data_addr;
        data_wdata_q <= data_wdata;
        data_wmask_q <= data_wmask;
      end else if (data_end_c) begin
        data_pend    <= 1'b0;
      end

      if (end_c || !wait_c)   tcnt <= '0;
      else if (TIMEOUT != 0)  tcnt <= tcnt + CNT_W'(1);

      // Aborted transactions complete with zero read data.
      fetch_done <= fetch_end_c;
      data_done  <= data_end_c;
      if (fetch_end_c)            fetch_data <= hs_c ? mem_rdata : '0;
      if (data_end_c && !mem_we)  data_rdata <= hs_c ? mem_rdata : '0;

      if (load_c) begin
        mem_addr  <= nxt_addr_c;
        mem_we    <= nxt_we_c;
        mem_wdata <= nxt_wdata_c;
        mem_wmask <= nxt_wmask_c;
      end

      if ((fetch_req && fetch_pend) || (data_req && data_pend) || abort_c) err <= 1'b1;
    end
  end

endmodule
